color_sequencer: RTL and testbench
==================================

Name: color_sequencer

Overview:
Sequencer that drives the target_color input of the LED fading controller. It steps through a fixed palette and waits for the fader's transition_done pulse. It then dwells on the reached colour for a programmable hold time before issuing the next target. It sits between the user-input debouncer (enable, step) and the fader, in the 50 MHz clk domain.

Parameters:
NUM_COLORS, 8, palette entries used (2..8); index wraps at NUM_COLORS-1
HOLD_CYCLES, 50_000_000, dwell cycles after a transition completes (1 s at 50 MHz)
TIMEOUT_CYCLES, 200_000_000, max cycles in FADE before forced advance to HOLD
GUARD_CYCLES, 2, cycles after entering FADE during which transition_done is ignored (min 1)

Ports:
clk  in  1  50 MHz system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run sequence, 0 = freeze in IDLE
step  in  1  single-cycle pulse (debounced); skip to next colour immediately
dir  in  1  0 = index increments, 1 = index decrements (both wrap)
transition_done  in  1  pulse from fader; colour reached
target_color  out  24  RGB target to fader, {R[23:16],G[15:8],B[7:0]}, registered
color_index  out  3  current palette index, registered
state  out  2  00 IDLE, 01 FADE, 10 HOLD
timeout_flag  out  1  sticky; set when FADE timeout fires, cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - target_color = 24'h000000, color_index = 0, state = IDLE, timeout_flag = 0.
  - All counters = 0.
- Palette:
  - Entries 0..7 = FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FFFFFF, 000000.
  - Entries at or above NUM_COLORS are unreachable.
- Next index, dir=0: (idx == NUM_COLORS-1) ? 0 : idx+1.
- Next index, dir=1: (idx == 0) ? NUM_COLORS-1 : idx-1.
- IDLE:
  - target_color and color_index held.
  - enable=1 → FADE next cycle; target_color <= palette[color_index] on the same edge. The index does not advance.
- FADE:
  - fade_cnt counts from 0 each entry.
  - transition_done is ignored while fade_cnt < GUARD_CYCLES. This masks stale done pulses, since the fader re-pulses done every frame while parked.
  - transition_done with fade_cnt >= GUARD_CYCLES → HOLD, hold_cnt <= 0.
  - fade_cnt == TIMEOUT_CYCLES-1 → HOLD, timeout_flag <= 1.
  - If done and timeout coincide, done wins; timeout_flag is not set.
- HOLD:
  - hold_cnt increments each cycle.
  - hold_cnt == HOLD_CYCLES-1 → compute next index; color_index, target_color <= new value; state <= FADE; fade_cnt <= 0. All on one edge.
  - transition_done is ignored in HOLD.
- step pulse in FADE or HOLD: immediately performs the index advance above, reloads target_color, enters/re-enters FADE with fade_cnt <= 0. step in IDLE is ignored.
- enable=0 in any state → IDLE next cycle. Takes priority over step, done, timeout and hold expiry on the same cycle. target_color and color_index are retained, so the fader finishes its current fade. Re-enable resumes with FADE to the retained index.
- Latency: step or hold expiry to new target_color = 1 cycle (registered output).
- Adjacent identical palette colours: the fader does not restart and keeps pulsing done. The sequencer accepts the first done after the guard; no special case.
- Counter widths: fade_cnt and hold_cnt are sized by $clog2 of the respective parameter. No wrap occurs, because state exits at terminal count.
- Reset mid-operation: all registers return to reset values asynchronously. After release, the block starts in IDLE.

Optional Feature:
SEQ_SHUFFLE_EN
- Defined:
  - A free-running 8-bit Fibonacci LFSR advances every clk cycle. Taps 8,6,5,4; seed 8'hA5 on reset; never all-zero.
  - Every index advance (hold expiry or step) uses cand = lfsr % NUM_COLORS; dir is ignored.
  - If cand == color_index, next index = cand+1 wrapped.
  - The index therefore never repeats consecutively.
- Undefined: the sequential dir-based stepping above; no LFSR logic is present.

Test Plan:
1. Reset, HOLD_CYCLES=10, GUARD=2, enable=1 → next cycle state=FADE, target_color=FF0000, color_index=0.
2. done pulse 5 cycles into FADE → HOLD. 10 cycles later target_color=00FF00, color_index=1, state=FADE.
3. done pulse at fade_cnt=1 (inside guard) → ignored, stays FADE. A second done at fade_cnt=4 → HOLD.
4. dir=1 at index 0, NUM_COLORS=8, step pulse in HOLD → color_index=7, target_color=000000, state=FADE next cycle.
5. TIMEOUT_CYCLES=100, no done → at fade_cnt=99 state=HOLD, timeout_flag=1. Flag stays 1 through later cycles until reset.
6. enable=0 and step on the same cycle during HOLD at index 2 → IDLE, color_index stays 2, target_color stays 0000FF. Re-enable → FADE with target 0000FF.

Source files
------------

// File: rtl/color_sequencer_if.sv
// Handshake bundle between the colour sequencer and its neighbours.
// The master modport belongs to the control side; the slave modport belongs to the sequencer.
interface color_sequencer_if;
  logic        enable;
  logic        step;
  logic        dir;
  logic        transition_done;
  logic [23:0] target_color;
  logic [2:0]  color_index;
  logic [1:0]  state;
  logic        timeout_flag;

  modport master (
    output enable, step, dir, transition_done,
    input  target_color, color_index, state, timeout_flag
  );

  modport slave (
    input  enable, step, dir, transition_done,
    output target_color, color_index, state, timeout_flag
  );
endinterface

// File: rtl/color_sequencer.sv
// Palette sequencer that feeds target colours to the LED fader and dwells after each fade.
// Define SEQ_SHUFFLE_EN to pick the next index pseudo-randomly from an 8-bit LFSR.
module color_sequencer #(
  parameter int NUM_COLORS     = 8,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int GUARD_CYCLES   = 2
) (
  input logic             clk,
  input logic             reset,
  color_sequencer_if.slave bus
);

  localparam int FW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [FW-1:0] TMO_LAST = FW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] GUARD_L  = FW'(GUARD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(NUM_COLORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FADE = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t        r_state;
  logic [23:0]   r_target;
  logic [2:0]    r_index;
  logic          r_tflag;
  logic [FW-1:0] r_fade_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [2:0]    w_next_idx;
  logic          w_done_ok;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 24'hFF0000;
      3'd1:    palette = 24'h00FF00;
      3'd2:    palette = 24'h0000FF;
      3'd3:    palette = 24'hFFFF00;
      3'd4:    palette = 24'h00FFFF;
      3'd5:    palette = 24'hFF00FF;
      3'd6:    palette = 24'hFFFFFF;
      default: palette = 24'h000000;
    endcase
  endfunction

`ifdef SEQ_SHUFFLE_EN
  logic [7:0] r_lfsr;
  logic [2:0] w_cand;

  // Fibonacci taps 8,6,5,4; the nonzero seed keeps it out of the lock-up state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  always_comb begin
    w_cand = 3'(r_lfsr % 8'(NUM_COLORS));
    if (w_cand != r_index) w_next_idx = w_cand;
    else                   w_next_idx = (w_cand == LAST_IDX) ? '0 : w_cand + 3'd1;
  end
`else
  always_comb begin
    if (!bus.dir) w_next_idx = (r_index == LAST_IDX) ? '0 : r_index + 3'd1;
    else          w_next_idx = (r_index == '0) ? LAST_IDX : r_index - 3'd1;
  end
`endif

  // Done pulses inside the guard window are stale repeats from the parked fader.
  assign w_done_ok = bus.transition_done && (r_fade_cnt >= GUARD_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_index    <= '0;
      r_tflag    <= 1'b0;
      r_fade_cnt <= '0;
      r_hold_cnt <= '0;
    end else if (!bus.enable) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FADE;
          r_target   <= palette(r_index);
          r_fade_cnt <= '0;
        end
        FADE: begin
          if (bus.step) begin
            r_index    <= w_next_idx;
            r_target   <= palette(w_next_idx);
            r_fade_cnt <= '0;
          end else if (w_done_ok) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
          end else if (r_fade_cnt == TMO_LAST) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
            r_tflag    <= 1'b1;
          end else begin
            r_fade_cnt <= r_fade_cnt + FW'(1);
          end
        end
        HOLD: begin
          if (bus.step || (r_hold_cnt == HOLD_LAST)) begin
            r_state    <= FADE;
            r_index    <= w_next_idx;
            r_target   <= palette(w_next_idx);
            r_fade_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.target_color = r_target;
  assign bus.color_index  = r_index;
  assign bus.state        = r_state;
  assign bus.timeout_flag = r_tflag;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer: fade/hold timing, guard, timeout, step, enable and reset.
// Uses NUM_COLORS=8, HOLD_CYCLES=10, TIMEOUT_CYCLES=100, GUARD_CYCLES=2.
module tb_color_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  color_sequencer_if bus();

  color_sequencer #(
    .NUM_COLORS(8),
    .HOLD_CYCLES(10),
    .TIMEOUT_CYCLES(100),
    .GUARD_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] idx,
                           input logic [23:0] col, input logic tf);
    check({tag, ".state"}, 24'(bus.state), 24'(st));
    check({tag, ".index"}, 24'(bus.color_index), 24'(idx));
    check({tag, ".color"}, bus.target_color, col);
    check({tag, ".tflag"}, 24'(bus.timeout_flag), 24'(tf));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.step = 1'b0;
    bus.dir = 1'b0;
    bus.transition_done = 1'b0;
    repeat (3) tick();
    check_all("reset", 2'b00, 3'd0, 24'h000000, 1'b0);
    reset = 1'b0;
    tick();
    check_all("idle_after_reset", 2'b00, 3'd0, 24'h000000, 1'b0);

    // Enable: first target issued without advancing the index
    bus.enable = 1'b1;
    tick();
    check_all("enable", 2'b01, 3'd0, 24'hFF0000, 1'b0);

    // Done five cycles into FADE, then ten-cycle hold
    repeat (4) tick();
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    check("done_to_hold", 24'(bus.state), 24'h2);
    repeat (9) tick();
    check("hold_not_expired", 24'(bus.state), 24'h2);
    tick();
    check_all("hold_expiry", 2'b01, 3'd1, 24'h00FF00, 1'b0);

    // Done inside the guard is ignored; a later one is accepted
    tick();
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    check("guard_ignore", 24'(bus.state), 24'h1);
    repeat (2) tick();
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    check_all("guard_pass", 2'b10, 3'd1, 24'h00FF00, 1'b0);

    // Step with dir=1 from index 1, then from index 0 (wrap to 7)
    bus.dir = 1'b1;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check_all("step_dec", 2'b01, 3'd0, 24'hFF0000, 1'b0);
    repeat (2) tick();
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    check("done_at_guard", 24'(bus.state), 24'h2);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.dir = 1'b0;
    check_all("step_wrap_dec", 2'b01, 3'd7, 24'h000000, 1'b0);

    // Done on the timeout cycle wins; no flag
    repeat (99) tick();
    check("fade_before_tmo", 24'(bus.state), 24'h1);
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    check_all("done_vs_tmo", 2'b10, 3'd7, 24'h000000, 1'b0);
    repeat (10) tick();
    check_all("wrap_inc", 2'b01, 3'd0, 24'hFF0000, 1'b0);

    // Timeout with no done
    repeat (99) tick();
    check_all("tmo_minus1", 2'b01, 3'd0, 24'hFF0000, 1'b0);
    tick();
    check_all("tmo_fire", 2'b10, 3'd0, 24'hFF0000, 1'b1);
    repeat (10) tick();
    check_all("tmo_sticky", 2'b01, 3'd1, 24'h00FF00, 1'b1);

    // Reach HOLD at index 2
    repeat (2) tick();
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check_all("step_inc", 2'b01, 3'd2, 24'h0000FF, 1'b1);
    repeat (2) tick();
    bus.transition_done = 1'b1;
    tick();
    bus.transition_done = 1'b0;
    check("hold_idx2", 24'(bus.state), 24'h2);

    // Disable and step together: disable wins
    bus.enable = 1'b0;
    bus.step = 1'b1;
    tick();
    check_all("disable_vs_step", 2'b00, 3'd2, 24'h0000FF, 1'b1);
    tick();
    bus.step = 1'b0;
    check_all("step_in_idle", 2'b00, 3'd2, 24'h0000FF, 1'b1);
    bus.enable = 1'b1;
    tick();
    check_all("reenable", 2'b01, 3'd2, 24'h0000FF, 1'b1);

    // Asynchronous reset mid-fade, checked before any clock edge
    #1;
    reset = 1'b1;
    #1;
    check_all("async_reset", 2'b00, 3'd0, 24'h000000, 1'b0);
    bus.enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_all("post_reset_idle", 2'b00, 3'd0, 24'h000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
